// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg : shared state encoding, opcode and mux-select constants for the
//              LC-3 branch sequencing controller.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EVAL      = 3'd2,
        S_TAKE_BR   = 3'd3,
        S_JUMP      = 3'd4,
        S_NOT_TAKEN = 3'd5,
        S_DONE      = 3'd6
    } branch_state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic       ADDR1_PC   = 1'b0;
    localparam logic       ADDR1_BASE = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // One-hot {N,Z,P} for a bus value; exactly one bit is ever set.
    function automatic logic [2:0] nzp_from_bus(input logic [15:0] bus);
        logic w_zero;
        w_zero = (bus == 16'h0000);
        return {bus[15], w_zero, ~bus[15] & ~w_zero};
    endfunction

endpackage

`default_nettype wire

// File: rtl/nzp_ben_reg.sv
// ---------------------------------------------------------------------------
// nzp_ben_reg : NZP condition-code register and BEN branch-enable register.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nzp_ben_reg
    import branch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cc_write,
    input  logic [15:0] i_bus,
    input  logic        i_ld_ben,
    input  logic [2:0]  i_ir_nzp,
    output logic        o_n,
    output logic        o_z,
    output logic        o_p,
    output logic        o_ben
);

    logic [2:0] r_nzp;
    logic       r_ben;
    logic       w_ben_next;

    // BEN samples the NZP currently held, so a same-cycle CC_Write is not seen.
    assign w_ben_next = (i_ir_nzp[2] & r_nzp[2]) |
                        (i_ir_nzp[1] & r_nzp[1]) |
                        (i_ir_nzp[0] & r_nzp[0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nzp <= 3'b010;
            r_ben <= 1'b0;
        end else begin
            if (i_cc_write) begin
                r_nzp <= nzp_from_bus(i_bus);
            end
            if (i_ld_ben) begin
                r_ben <= w_ben_next;
            end
        end
    end

    assign o_n   = r_nzp[2];
    assign o_z   = r_nzp[1];
    assign o_p   = r_nzp[0];
    assign o_ben = r_ben;

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl : LC-3 branch sequencing controller (BR / JMP), fixed 4-cycle
//               Start-to-Done latency. Optional BRANCH_STATS_EN adds
//               taken / not-taken event counters.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_ctrl
    import branch_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IR,
    input  logic        CC_Write,
    input  logic [15:0] Bus,
    output logic        LD_BEN,
    output logic        LD_PC,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [2:0]  SR1,
    output logic        Busy,
    output logic        Done,
    output logic        N,
    output logic        Z,
    output logic        P,
    output logic        BEN
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] Taken_Count,
    output logic [15:0] NotTaken_Count
`endif
);

    branch_state_t r_state;
    branch_state_t w_next;

    logic          w_ld_ben;
    logic          w_ld_pc;
    logic [1:0]    w_pcmux;
    logic          w_addr1mux;
    logic [1:0]    w_addr2mux;
    logic [2:0]    w_sr1;
    logic          w_done;
    logic          w_ben;
    logic          w_ir_unused;

    assign w_ir_unused = ^IR[5:0];

    nzp_ben_reg u_nzp_ben_reg (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_cc_write (CC_Write),
        .i_bus      (Bus),
        .i_ld_ben   (w_ld_ben),
        .i_ir_nzp   (IR[11:9]),
        .o_n        (N),
        .o_z        (Z),
        .o_p        (P),
        .o_ben      (w_ben)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ld_ben   = 1'b0;
        w_ld_pc    = 1'b0;
        w_pcmux    = PCMUX_PC1;
        w_addr1mux = ADDR1_PC;
        w_addr2mux = ADDR2_ZERO;
        w_sr1      = 3'b000;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ld_ben = 1'b1;
                w_next   = S_EVAL;
            end
            S_EVAL: begin
                if (IR[15:12] == OP_BR) begin
                    w_next = w_ben ? S_TAKE_BR : S_NOT_TAKEN;
                end else if (IR[15:12] == OP_JMP) begin
                    w_next = S_JUMP;
                end else begin
                    w_next = S_NOT_TAKEN;
                end
            end
            S_TAKE_BR: begin
                w_ld_pc    = 1'b1;
                w_pcmux    = PCMUX_ADDER;
                w_addr1mux = ADDR1_PC;
                w_addr2mux = ADDR2_OFF9;
                w_next     = S_DONE;
            end
            S_JUMP: begin
                w_ld_pc = 1'b1;
                w_pcmux = PCMUX_BUS;
                w_sr1   = IR[8:6];
                w_next  = S_DONE;
            end
            S_NOT_TAKEN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign LD_BEN   = w_ld_ben;
    assign LD_PC    = w_ld_pc;
    assign PCMUX    = w_pcmux;
    assign ADDR1MUX = w_addr1mux;
    assign ADDR2MUX = w_addr2mux;
    assign SR1      = w_sr1;
    assign Busy     = (r_state != S_IDLE);
    assign Done     = w_done;
    assign BEN      = w_ben;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_not_taken_cnt;

    // Counting on the EVAL exit edge makes each count coincide with state entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_taken_cnt     <= 16'h0000;
            r_not_taken_cnt <= 16'h0000;
        end else if (r_state == S_EVAL) begin
            if (w_next == S_TAKE_BR || w_next == S_JUMP) begin
                r_taken_cnt <= r_taken_cnt + 16'h0001;
            end else if (w_next == S_NOT_TAKEN) begin
                r_not_taken_cnt <= r_not_taken_cnt + 16'h0001;
            end
        end
    end

    assign Taken_Count    = r_taken_cnt;
    assign NotTaken_Count = r_not_taken_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/branch_ctrl.md
# branch_ctrl

Branch sequencing controller for the LC-3 datapath. Owns the NZP condition-code register and the BEN (branch enable) register. On a start strobe from the main control FSM, it sequences the BEN load, evaluates BR/JMP, drives the PC mux and address-adder selects, and pulses Done. It sits beside the main ISDU and takes over PC control only for branch-class instructions.

## Interface
Parameters:
- none (widths fixed by LC-3 ISA)

Ports:
- Clk  input  1  single system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle strobe; IR holds a decoded branch-class instruction
- IR  input  16  instruction register contents, stable from Start until Done
- CC_Write  input  1  latch NZP from Bus this cycle
- Bus  input  16  datapath bus value, used for NZP generation
- LD_BEN  output  1  BEN load strobe, also drives internal BEN register
- LD_PC  output  1  PC load strobe
- PCMUX  output  2  00 = PC+1, 01 = Bus, 10 = address adder
- ADDR1MUX  output  1  0 = PC, 1 = base register
- ADDR2MUX  output  2  00 = zero, 01 = offset6, 10 = offset9, 11 = offset11
- SR1  output  3  register-file read select (JMP base register)
- Busy  output  1  high in any state other than IDLE
- Done  output  1  one-cycle completion pulse
- N, Z, P  output  1 each  current condition codes
- BEN  output  1  current branch-enable register value

## Operation
- NZP register:
  - On CC_Write, N = Bus[15]; Z = (Bus == 0); P = !Bus[15] & (Bus != 0).
  - Exactly one of N/Z/P is high at all times.
- BEN register:
  - On LD_BEN, BEN <= (IR[11] & N) | (IR[10] & Z) | (IR[9] & P).
  - This is a logical OR, never an arithmetic sum.
- FSM states: IDLE, DECODE, EVAL, TAKE_BR, JUMP, NOT_TAKEN, DONE.
- Transitions:
  - IDLE -> DECODE on Start.
  - DECODE: LD_BEN = 1 -> EVAL.
  - EVAL:
    - IR[15:12] = 0000 and BEN -> TAKE_BR.
    - IR[15:12] = 0000 and !BEN -> NOT_TAKEN.
    - IR[15:12] = 1100 -> JUMP.
    - Any other opcode -> NOT_TAKEN.
  - TAKE_BR: LD_PC = 1, PCMUX = 10, ADDR1MUX = 0, ADDR2MUX = 10 -> DONE.
  - JUMP: LD_PC = 1, PCMUX = 01, SR1 = IR[8:6] -> DONE.
  - NOT_TAKEN: no PC load -> DONE.
  - DONE: Done = 1 -> IDLE.
- Output defaults in every state unless listed above: LD_BEN = 0, LD_PC = 0, PCMUX = 00, ADDR1MUX = 0, ADDR2MUX = 00, SR1 = 000.
- Start while Busy is ignored; no queueing.
- CC_Write is honoured in every state, including during a sequence.

## Timing
- Start sampled at edge 0. DECODE occupies cycle 1, EVAL cycle 2, TAKE_BR/JUMP/NOT_TAKEN cycle 3, Done high in cycle 4. Busy is high in cycles 1–4.
- Latency from Start to Done is 4 cycles, fixed for all paths.
- CC_Write in the same cycle as LD_BEN: BEN uses the pre-update NZP; the new NZP is visible one cycle later.
- All control outputs are Moore, decoded from the registered state only.
- Reset values: state IDLE, N = 0, Z = 1, P = 0, BEN = 0, Done = 0, Busy = 0, all strobes and selects 0.
- Reset mid-sequence returns to IDLE next edge. No LD_PC is issued after a Reset edge.
- Reset has priority over CC_Write and Start.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs Taken_Count[15:0] and NotTaken_Count[15:0].
  - Taken_Count increments on entry to TAKE_BR or JUMP.
  - NotTaken_Count increments on entry to NOT_TAKEN.
  - Both counters wrap at 16'hFFFF -> 0 and clear on Reset.
- BRANCH_STATS_EN undefined:
  - The counter ports and logic are absent.
  - Behaviour is otherwise identical.

## Structure
- Shared package branch_pkg holds:
  - State enum branch_state_t.
  - Opcode constants OP_BR = 4'b0000, OP_JMP = 4'b1100.
  - PCMUX constants PCMUX_PC1, PCMUX_BUS, PCMUX_ADDER.
  - ADDR2MUX constants for zero, offset6, offset9, offset11.
- One sub-module, nzp_ben_reg, contains the NZP and BEN registers and their update logic.
- The top level holds the FSM and the optional counters.

## Test plan
- Reset, then no stimulus -> N/Z/P = 0/1/0, BEN = 0, Busy = 0, all strobes 0.
- CC_Write with Bus = 16'h8000, then Start with IR = 16'h0800 (BRn) -> LD_BEN in cycle 1; cycle 3 LD_PC = 1, PCMUX = 10, ADDR2MUX = 10; Done in cycle 4.
- CC_Write with Bus = 16'h0005, then Start with IR = 16'h0800 -> BEN = 0, NOT_TAKEN, LD_PC never high, Done in cycle 4.
- Start with IR = 16'hC1C0 (JMP R7) -> cycle 3 LD_PC = 1, PCMUX = 01, SR1 = 3'b111.
- Z set, then CC_Write with Bus = 16'h0001 in the same cycle as LD_BEN, IR = 16'h0400 (BRz) -> BEN = 1 (old Z); P visible the next cycle.
- Reset asserted in EVAL -> IDLE next edge, no LD_PC, NZP = 010; a second Start during Busy is ignored. With BRANCH_STATS_EN, two taken branches plus one not-taken -> counts 2 and 1.
